// File: rtl/fsm_scan.sv
// "Three consecutive ones" Moore detector whose 2-bit state register is also
// a two-flop scan chain: scan_in -> state[0] -> state[1] -> scan_out.
module fsm_scan (
  input  logic       clk,
  input  logic       reset,
  input  logic       in,
  input  logic       scan_en,
  input  logic       scan_in,
  output logic       scan_out,
  output logic [1:0] state_out
);

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } state_t;

  state_t state, state_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S0;
    else       state <= state_nxt;
  end

  // Scan shift takes priority over the functional transition; in is ignored then.
  always_comb begin
    state_nxt = state;
    if (scan_en) begin
      state_nxt = state_t'({state[0], scan_in});
    end else if (!in) begin
      state_nxt = S0;
    end else begin
      case (state)
        S0:      state_nxt = S1;
        S1:      state_nxt = S2;
        S2:      state_nxt = S3;
        default: state_nxt = S3;
      endcase
    end
  end

  assign state_out = state;
  assign scan_out  = state[1];

endmodule

// File: tb/tb_fsm_scan.sv
// Directed plus randomized bench for fsm_scan against a run-length / shift-register model.
module tb_fsm_scan;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_d;
  logic       scan_en;
  logic       scan_in;
  logic       scan_out;
  logic [1:0] state_out;

  int vectors = 0;
  int miscompares = 0;
  int model = 0;

  fsm_scan dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in_d),
    .scan_en   (scan_en),
    .scan_in   (scan_in),
    .scan_out  (scan_out),
    .state_out (state_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag);
    logic [1:0] exp_state;
    exp_state = 2'(model);
    vectors++;
    assert (state_out === exp_state) else begin
      miscompares++;
      $error("FAIL %s state_out observed=%b expected=%b", tag, state_out, exp_state);
    end
    vectors++;
    assert (scan_out === exp_state[1]) else begin
      miscompares++;
      $error("FAIL %s scan_out observed=%b expected=%b", tag, scan_out, exp_state[1]);
    end
  endtask

  // Applies one cycle of inputs; exp >= 0 additionally pins state_out to a literal.
  task automatic step(input logic i, input logic se, input logic si, input int exp,
                      input string tag);
    @(negedge clk);
    in_d = i;
    scan_en = se;
    scan_in = si;
    @(posedge clk);
    if (se) model = (model * 2 + int'(si)) % 4;
    else    model = i ? ((model < 3) ? model + 1 : 3) : 0;
    #1;
    chk(tag);
    if (exp >= 0) begin
      vectors++;
      assert (state_out === 2'(exp)) else begin
        miscompares++;
        $error("FAIL %s literal observed=%b expected=%b", tag, state_out, 2'(exp));
      end
    end
  endtask

  // Asserts reset between edges, holds it across one edge, releases it mid-cycle.
  task automatic mid_reset(input string tag);
    #2 reset = 1'b1;
    model = 0;
    #1 chk({tag, "_async"});
    @(posedge clk);
    #1 chk({tag, "_hold"});
    #2 reset = 1'b0;
    #1 chk({tag, "_release"});
  endtask

  initial begin
    reset = 1'b1;
    in_d = 1'b0;
    scan_en = 1'b0;
    scan_in = 1'b0;
    @(posedge clk);
    #1 chk("reset_init");
    @(negedge clk);
    reset = 1'b0;
    model = 0;

    // Functional detect 0,1,1,1,1
    step(0, 0, 0, 0, "det0");
    step(1, 0, 0, 1, "det1");
    step(1, 0, 0, 2, "det2");
    step(1, 0, 0, 3, "det3");
    step(1, 0, 1, 3, "det4");

    // Reset mid-cycle from S3
    mid_reset("rst_s3");
    step(1, 0, 0, 1, "post_rst");

    // Sequence breaks
    step(1, 0, 0, 2, "brk_s2");
    step(0, 0, 0, 0, "brk_s2_0");
    step(1, 0, 0, 1, "brk_restart");
    step(1, 0, 0, 2, "brk_a");
    step(1, 0, 0, 3, "brk_b");
    step(0, 0, 0, 0, "brk_s3_0");

    // Scan shift with mode switching from S3
    step(1, 0, 0, 1, "to_s3_a");
    step(1, 0, 0, 2, "to_s3_b");
    step(1, 0, 0, 3, "to_s3_c");
    step(1, 1, 0, 2, "scan_sh0");
    step(0, 1, 1, 1, "scan_sh1");
    step(1, 0, 0, 2, "scan_back_func");

    // Scan load/unload from 00 with in toggling
    step(0, 0, 1, 0, "clr");
    step(1, 1, 1, 1, "load1");
    step(0, 1, 1, 3, "load2");
    step(1, 1, 0, 2, "unload1");
    step(0, 1, 0, 0, "unload2");

    // scan_in ignored in functional mode
    for (int k = 0; k < 6; k++) step(0, 0, logic'(k[0]), 0, "ign_scan_in");
    // in ignored in scan mode
    for (int k = 0; k < 6; k++) step(logic'(k[0]), 1, logic'(k[1]), -1, "ign_in");

    // Randomized traffic with occasional mid-cycle resets
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 39) == 0) mid_reset("rnd_rst");
      else step(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 3) == 0),
                logic'($urandom_range(0, 1)), -1, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout vectors=%0d", vectors);
    $fatal(1, "timeout");
  end

endmodule
